// File: rtl/micro_sequencer_core_v2.sv
// micro_sequencer_core_v2: fetches 64-bit instructions from program BRAM and drives pulse/IRQ outputs
module micro_sequencer_core_v2 #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int BRAM_LATENCY    = 2,
  parameter int PULSE_WIDTH     = 32,
  parameter int NUM_COUNTERS    = 4,
  parameter int NUM_IRQ         = 4
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESETN,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] start_addr,
  input  logic                       abort,
  input  logic                       unpause,
  output logic                       bram_porta_clk,
  output logic                       bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata,
  output logic [PULSE_WIDTH-1:0]     pulse,
  output logic [BRAM_ADDR_WIDTH-1:0] pc,
  output logic                       busy,
  output logic                       paused,
  output logic                       error,
  output logic [NUM_IRQ-1:0]         ps_interrupts
);
  if (BRAM_DATA_WIDTH != 64) begin : g_width_check
    $error("BRAM_DATA_WIDTH must be 64");
  end
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_PAUSED} state_t;
  localparam logic [5:0] OP_HALT = 6'h01, OP_SET = 6'h02, OP_WAIT = 6'h03, OP_LDC = 6'h04;
  localparam logic [5:0] OP_DJNZ = 6'h05, OP_JMP = 6'h06, OP_PAUSE = 6'h07, OP_IRQ = 6'h08;
  state_t                     r_state, w_next;
  logic [BRAM_ADDR_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc, w_tgt;
  logic [63:0]                r_instr;
  logic [2:0]                 r_fcnt;
  logic [31:0]                r_wcnt;
  logic [31:0]                r_cnt [NUM_COUNTERS];
  logic [PULSE_WIDTH-1:0]     r_pulse;
  logic                       r_err;
  logic [NUM_IRQ-1:0]         r_irq, w_irq_set;
  logic [5:0]                 w_op;
  logic [1:0]                 w_idx;
  logic [31:0]                w_imm, w_cnt_cur, w_dec, w_cnt_wd;
  logic                       w_cnt_we, w_illegal, w_exec, w_go, w_fetch_done, w_unused;
  assign w_op         = r_instr[63:58];
  assign w_idx        = r_instr[57:56];
  assign w_tgt        = r_instr[32+BRAM_ADDR_WIDTH-1:32];
  assign w_imm        = r_instr[31:0];
  assign w_unused     = ^r_instr[55:32+BRAM_ADDR_WIDTH];
  assign w_fetch_done = r_fcnt == 3'(BRAM_LATENCY-1);
  // An index beyond the instantiated counters/IRQ lines is treated like a bad opcode
  assign w_illegal = (w_op > OP_IRQ) ||
                     ((w_op == OP_LDC || w_op == OP_DJNZ) && int'(w_idx) >= NUM_COUNTERS) ||
                     (w_op == OP_IRQ && int'(w_idx) >= NUM_IRQ);
  assign w_exec   = r_state == S_EXEC && !abort && !w_illegal;
  assign w_go     = r_state == S_IDLE && start && !abort;
  assign w_dec    = w_cnt_cur - 1;
  assign w_cnt_we = w_exec && (w_op == OP_LDC || w_op == OP_DJNZ);
  assign w_cnt_wd = w_op == OP_LDC ? w_imm : w_dec;
  assign w_pc_inc = r_pc + 1'b1;
  assign w_pc_nxt = w_go ? start_addr :
                    !w_exec ? r_pc :
                    w_op == OP_HALT ? r_pc :
                    (w_op == OP_JMP || (w_op == OP_DJNZ && w_dec != '0)) ? w_tgt : w_pc_inc;
  always_comb begin
    w_cnt_cur = '0;
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (w_idx == 2'(i)) w_cnt_cur = r_cnt[i];
  end
  always_comb begin
    w_irq_set = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      w_irq_set[i] = w_exec && w_op == OP_IRQ && w_idx == 2'(i);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = w_fetch_done ? S_EXEC : S_FETCH;
      S_EXEC:   w_next = (w_illegal || w_op == OP_HALT) ? S_IDLE :
                         (w_op == OP_WAIT && w_imm != '0) ? S_WAIT :
                         w_op == OP_PAUSE ? S_PAUSED : S_FETCH;
      S_WAIT:   w_next = r_wcnt == 32'd1 ? S_FETCH : S_WAIT;
      S_PAUSED: w_next = unpause ? S_FETCH : S_PAUSED;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_fcnt  <= '0;
      r_wcnt  <= '0;
      r_pulse <= '0;
      r_err   <= 1'b0;
      r_irq   <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      r_fcnt  <= r_state == S_FETCH ? r_fcnt + 1'b1 : '0;
      if (r_state == S_FETCH && w_fetch_done) r_instr <= bram_porta_rddata;
      r_wcnt  <= (w_exec && w_op == OP_WAIT) ? w_imm : r_state == S_WAIT ? r_wcnt - 1 : r_wcnt;
      r_pulse <= abort ? '0 : (w_exec && w_op == OP_SET) ? w_imm[PULSE_WIDTH-1:0] : r_pulse;
      r_err   <= w_go ? 1'b0 : (r_state == S_EXEC && !abort && w_illegal) ? 1'b1 : r_err;
      r_irq   <= w_irq_set;
      for (int i = 0; i < NUM_COUNTERS; i++)
        if (w_cnt_we && w_idx == 2'(i)) r_cnt[i] <= w_cnt_wd;
    end
  end
  assign bram_porta_clk  = S_AXI_ACLK;
  assign bram_porta_rst  = ~S_AXI_ARESETN;
  assign bram_porta_addr = r_pc;
  assign pc              = r_pc;
  assign pulse           = r_pulse;
  assign busy            = r_state != S_IDLE;
  assign paused          = r_state == S_PAUSED;
  assign error           = r_err;
  assign ps_interrupts   = r_irq;
endmodule

// File: tb/tb_micro_sequencer_core_v2.sv
// tb_micro_sequencer_core_v2: scoreboard bench; expected output changes are queued, a monitor pops on each change
module tb_micro_sequencer_core_v2;
  localparam int AW = 4;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, unpause = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          bclk, brst, busy, paused, error;
  logic [AW-1:0] baddr, pc;
  logic [63:0]   rddata = '0;
  logic [31:0]   pulse;
  logic [3:0]    irq;
  logic [63:0]   mem [16];
  micro_sequencer_core_v2 #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(64), .BRAM_LATENCY(2),
                            .PULSE_WIDTH(32), .NUM_COUNTERS(4), .NUM_IRQ(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .start_addr(start_addr),
    .abort(abort), .unpause(unpause), .bram_porta_clk(bclk), .bram_porta_rst(brst),
    .bram_porta_addr(baddr), .bram_porta_rddata(rddata), .pulse(pulse), .pc(pc),
    .busy(busy), .paused(paused), .error(error), .ps_interrupts(irq));
  always #5 clk = ~clk;
  always_ff @(posedge clk) rddata <= mem[baddr];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {string nm; logic [38:0] obs; int dly;} ev_t;
  ev_t         q[$];
  ev_t         e_m;
  int          total = 0, bad = 0, last = 0;
  bit          mon_en = 1'b0;
  logic [38:0] prev;
  wire  [38:0] obs = {busy, paused, error, irq, pulse};
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic ev(string nm, bit b, bit p, bit e, logic [3:0] i, logic [31:0] pl, int d);
    q.push_back('{nm, {b, p, e, i, pl}, d});
  endtask
  always @(negedge clk) begin
    if (!mon_en) begin
      prev = obs;
      last = cyc;
    end else if (obs !== prev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: got %0h expected %0h", obs, prev);
      end else begin
        e_m = q.pop_front();
        chk(e_m.nm, obs, e_m.obs);
        if (e_m.dly >= 0) chk({e_m.nm, "_delay"}, cyc - last, e_m.dly);
      end
      prev = obs;
      last = cyc;
    end
  end
  function automatic logic [63:0] ins(logic [5:0] op, logic [1:0] idx, logic [23:0] tgt, logic [31:0] imm);
    return {op, idx, tgt, imm};
  endfunction
  task automatic start_at(logic [AW-1:0] a);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(string nm, int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({"idle_", nm}, busy, 0);
  endtask
  task automatic clear_mem();
    foreach (mem[i]) mem[i] = ins(6'h01, 0, 0, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    clear_mem();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_pc", pc, 0);
    chk("rst_err_irq_paused", {error, irq, paused}, 0);
    chk("rst_bram_rst", brst, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    // SET/WAIT/SET/HALT: pulse high for 3+10+3 cycles
    mem[0] = ins(6'h02, 0, 0, 32'hA5);
    mem[1] = ins(6'h03, 0, 0, 32'd10);
    mem[2] = ins(6'h02, 0, 0, 32'h0);
    mem[3] = ins(6'h01, 0, 0, 0);
    ev("t1_busy", 1, 0, 0, 0, 0, -1);
    ev("t1_set", 1, 0, 0, 0, 32'hA5, 3);
    ev("t1_clr", 1, 0, 0, 0, 0, 16);
    ev("t1_halt", 0, 0, 0, 0, 0, 3);
    start_at(0);
    wait_idle("t1", 100);
    chk("t1_pc", pc, 3);
    // counter loop: three pulse[0] periods
    clear_mem();
    mem[0] = ins(6'h04, 1, 0, 32'd3);
    mem[1] = ins(6'h02, 0, 0, 32'h1);
    mem[2] = ins(6'h02, 0, 0, 32'h0);
    mem[3] = ins(6'h05, 1, 24'd1, 0);
    mem[4] = ins(6'h01, 0, 0, 0);
    ev("t2_busy", 1, 0, 0, 0, 0, -1);
    for (int k = 0; k < 3; k++) begin
      ev("t2_hi", 1, 0, 0, 0, 1, 6);
      ev("t2_lo", 1, 0, 0, 0, 0, 3);
    end
    ev("t2_halt", 0, 0, 0, 0, 0, 6);
    start_at(0);
    wait_idle("t2", 200);
    chk("t2_counter1", dut.r_cnt[1], 0);
    // pause held for 50 cycles
    clear_mem();
    mem[5] = ins(6'h07, 0, 0, 0);
    mem[6] = ins(6'h02, 0, 0, 32'h3C);
    mem[7] = ins(6'h01, 0, 0, 0);
    ev("t3_busy", 1, 0, 0, 0, 0, -1);
    ev("t3_pause", 1, 1, 0, 0, 0, 3);
    ev("t3_resume", 1, 0, 0, 0, 0, 50);
    ev("t3_set", 1, 0, 0, 0, 32'h3C, 3);
    ev("t3_halt", 0, 0, 0, 0, 32'h3C, 3);
    start_at(5);
    repeat (52) @(negedge clk);
    unpause = 1'b1;
    @(negedge clk);
    unpause = 1'b0;
    chk("t3_fetch_addr", baddr, 6);
    wait_idle("t3", 100);
    chk("t3_pc", pc, 7);
    // IRQ strobe, then illegal opcode, then restart clears error
    clear_mem();
    mem[8] = ins(6'h08, 2, 0, 0);
    mem[9] = ins(6'h3F, 0, 0, 0);
    ev("t4_busy", 1, 0, 0, 0, 32'h3C, -1);
    ev("t4_irq", 1, 0, 0, 4'b0100, 32'h3C, 3);
    ev("t4_irq_off", 1, 0, 0, 0, 32'h3C, 1);
    ev("t4_err", 0, 0, 1, 0, 32'h3C, 2);
    start_at(8);
    wait_idle("t4", 100);
    chk("t4_error", error, 1);
    ev("t4_restart", 1, 0, 0, 0, 32'h3C, -1);
    ev("t4_halt", 0, 0, 0, 0, 32'h3C, 3);
    start_at(10);
    wait_idle("t4b", 100);
    // abort during long WAIT, with a simultaneous start
    clear_mem();
    mem[11] = ins(6'h02, 0, 0, 32'hFF);
    mem[12] = ins(6'h03, 0, 0, 32'd1000);
    ev("t5_busy", 1, 0, 0, 0, 32'h3C, -1);
    ev("t5_set", 1, 0, 0, 0, 32'hFF, 3);
    ev("t5_abort", 0, 0, 0, 0, 0, 97);
    start_at(11);
    repeat (99) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    start_addr = 0;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_pulse", pulse, 0);
    repeat (2) @(negedge clk);
    chk("t5_still_idle", busy, 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_idle_start_abort", busy, 0);
    // pc wraps 15 -> 0
    clear_mem();
    mem[15] = ins(6'h00, 0, 0, 0);
    ev("t6_busy", 1, 0, 0, 0, 0, -1);
    ev("t6_halt", 0, 0, 0, 0, 0, 6);
    start_at(15);
    repeat (3) @(negedge clk);
    chk("t6_wrap_addr", baddr, 0);
    wait_idle("t6", 100);
    chk("t6_pc", pc, 0);
    // asynchronous reset in the middle of a WAIT
    clear_mem();
    mem[1] = ins(6'h02, 0, 0, 32'h55);
    mem[2] = ins(6'h03, 0, 0, 32'd100);
    ev("t7_busy", 1, 0, 0, 0, 0, -1);
    ev("t7_set", 1, 0, 0, 0, 32'h55, 3);
    start_at(1);
    repeat (10) @(negedge clk);
    chk("t7_in_wait", busy, 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_pulse", pulse, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_pc", pc, 0);
    chk("t7_rst_flags", {paused, error, irq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
